// File: rtl/periph_bus_bridge.sv
// periph_bus_bridge: host valid/ready requests to single-cycle peripheral strobes.
// Requests are queued in a small FIFO, one transaction is in flight at a time,
// and reads the peripheral never answers complete with rsp_error after TIMEOUT cycles.
module periph_bus_bridge #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              per_read,
  output logic              per_write,
  output logic [ADDR_W-1:0] per_address,
  output logic [DATA_W-1:0] per_data_out,
  input  logic              per_read_valid,
  input  logic [DATA_W-1:0] per_data_in,
  output logic              busy
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(TIMEOUT + 1);
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t state;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_head;

  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [CNT_W-1:0]  wait_cnt;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_error_q;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

  // Queue storage needs no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {req_write, req_addr, req_wdata};
    end
  end

  // Advance write pointer on accept and read pointer when IDLE takes the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  // Transaction FSM: one command in flight, response held until the host takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd_write   <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      wait_cnt    <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {cmd_write, cmd_addr, cmd_wdata} <= fifo_head;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_write) begin
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            state       <= RESP;
          end else begin
            wait_cnt <= '0;
            state    <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (per_read_valid) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= per_data_in;
            rsp_error_q <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and response fields are decoded from registered state only.
  assign per_write    = (state == ISSUE) && cmd_write;
  assign per_read     = (state == ISSUE) && !cmd_write;
  assign per_address  = (state == ISSUE) ? cmd_addr : '0;
  assign per_data_out = ((state == ISSUE) && cmd_write) ? cmd_wdata : '0;

  assign rsp_valid = (state == RESP);
  assign rsp_write = (state == RESP) && rsp_write_q;
  assign rsp_rdata = (state == RESP) ? rsp_rdata_q : '0;
  assign rsp_error = (state == RESP) && rsp_error_q;

  assign busy = (state != IDLE) || !fifo_empty;

endmodule
